keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 active-low key matrix, debounces it, and turns each accepted key press into the keypad, operator and equal strobes that the calculator controller consumes. It is the transmitting end of the controller's keypad/operator interface and sits between the board-level matrix pins and the controller. The block is fully synchronous to one clock. It emits exactly one event per physical press.

## Interface
- SCAN_DIV, 16: clock cycles each column is driven; must be >= 3.
- DEBOUNCE_CYCLES, 1000: consecutive stable cycles required for press and for release; must be >= 2.
- clk  input  1  system clock
- RST  input  1  asynchronous, active-high reset
- row_in  input  4  matrix rows, active-low, externally pulled up
- col_out  output  4  column drive, one-hot-low
- keypad_input  output  4  last accepted digit 0-9
- read_input  output  1  one-cycle strobe; keypad_input is valid in the same cycle
- operator_input  output  3  held one-hot operator: 001 add, 010 sub, 100 mul; 000 none
- equal_input  output  1  one-cycle strobe for '='
- clear_input  output  1  one-cycle strobe for '*'; tied 0 unless KEYPAD_CLEAR_EN is defined

## Operation
- row_in passes through a 2-flop synchronizer before any use.
- Key map (row, col):
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: * 0 # D
  - A = add, B = sub, C = mul, D = equal, # = ignored (no strobe).
- States:
  - SCAN: drive column c low for SCAN_DIV cycles. On the last dwell cycle, sample the synced rows. If any row is low, latch c and the lowest low row index, then go to DEBOUNCE. Otherwise advance c (3 wraps to 0).
  - DEBOUNCE: hold the column. Count cycles in which the synced row pattern equals the latched pattern. On a mismatch, clear the count and return to SCAN on the same column. When the count reaches DEBOUNCE_CYCLES, go to EMIT.
  - EMIT: one cycle. Digit: load keypad_input and pulse read_input. A/B/C: load operator_input. D: pulse equal_input. '*': see Configuration. Then go to RELEASE.
  - RELEASE: hold the column. Count consecutive cycles in which all synced rows are high; any low row clears the count. At DEBOUNCE_CYCLES, go to SCAN with column 0.
- operator_input holds until the next operator key, a clear, or reset. '=' does not clear it.
- Keys in other columns pressed while the block is in DEBOUNCE or RELEASE are ignored, not queued.

## Timing
- Reset values:
  - col_out = 4'b1110
  - keypad_input = 0, operator_input = 0
  - read_input, equal_input, clear_input = 0
  - state = SCAN, column = 0, counters = 0
- Strobes last exactly one cycle and are mutually exclusive.
- Press latency: at most 4*SCAN_DIV + 2 (synchronizer) + DEBOUNCE_CYCLES + 1 cycles from a stable press to its strobe.
- Minimum interval between two accepted presses: 2*DEBOUNCE_CYCLES + 2 cycles.
- Two keys pressed in one column: the lower row index wins. Releasing it while the other key is still held keeps the block in RELEASE.
- RST asserted mid-operation: immediate return to the reset values. No strobe is emitted for a press that was interrupted.

## Configuration
- KEYPAD_CLEAR_EN defined: '*' pulses clear_input in EMIT and zeroes operator_input in the same cycle.
- KEYPAD_CLEAR_EN undefined: '*' is treated like '#' (debounced, no strobe), and clear_input is constant 0.

## Structure
- Shared package calc_pkg holds:
  - op_t one-hot constants OP_NONE, OP_ADD, OP_SUB, OP_MUL
  - key_code_t enum (K0..K9, K_ADD, K_SUB, K_MUL, K_EQ, K_STAR, K_HASH)
  - the scanner state enum
- Sub-module keypad_debounce: counter with match/clear inputs and a done output. It is used for both press and release.
- The row/column to key_code_t decode is a package function.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_CYCLES=8.
- Hold key '7' (row2, col0) steady -> one read_input pulse with keypad_input=7, within 4*4+2+8+1 = 27 cycles; no further pulse while held.
- Press 'B' clean -> operator_input=010 and stays 010; then press 'D' -> one equal_input pulse and operator_input still 010.
- Bounce '5' (low 3 cycles, high 1 cycle, repeated 5 times, then stable) -> exactly one read_input pulse with keypad_input=5.
- Hold '1' and '4' together (col0, rows 0 and 1) -> single keypad_input=1 strobe; release '1' only -> no strobe until both are released.
- Assert RST during DEBOUNCE of '9' -> all outputs go to their reset values immediately; no read_input pulse.
- With KEYPAD_CLEAR_EN defined, press 'C' then '*' -> operator_input=100, then a clear_input pulse with operator_input=000. Without the macro -> operator_input stays 100 and clear_input stays 0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator types: operator codes, key codes,
// scanner states and the matrix-position to key decode.
package calc_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_NONE = 3'b000;
    localparam op_t OP_ADD  = 3'b001;
    localparam op_t OP_SUB  = 3'b010;
    localparam op_t OP_MUL  = 3'b100;

    typedef enum logic [3:0] {
        K0, K1, K2, K3, K4, K5, K6, K7, K8, K9,
        K_ADD, K_SUB, K_MUL, K_EQ, K_STAR, K_HASH
    } key_code_t;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_EMIT,
        ST_RELEASE
    } scan_state_t;

    // Matrix position (row, col) to key code
    function automatic key_code_t key_decode(
        input logic [1:0] row,
        input logic [1:0] col
    );
        key_code_t k;
        k = K_HASH;
        unique case ({row, col})
            4'h0: k = K1;
            4'h1: k = K2;
            4'h2: k = K3;
            4'h3: k = K_ADD;
            4'h4: k = K4;
            4'h5: k = K5;
            4'h6: k = K6;
            4'h7: k = K_SUB;
            4'h8: k = K7;
            4'h9: k = K8;
            4'hA: k = K9;
            4'hB: k = K_MUL;
            4'hC: k = K_STAR;
            4'hD: k = K0;
            4'hE: k = K_HASH;
            4'hF: k = K_EQ;
        endcase
        return k;
    endfunction

    // Lowest-numbered active-low row
    function automatic logic [1:0] low_row(
        input logic [3:0] rows
    );
        logic [1:0] r;
        r = 2'd3;
        if (!rows[0])      r = 2'd0;
        else if (!rows[1]) r = 2'd1;
        else if (!rows[2]) r = 2'd2;
        return r;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Stable-cycle counter shared by press and release
// qualification; done holds once CYCLES matches are seen.
module keypad_debounce #(
    parameter int CYCLES = 1000
) (
    input  logic clk,
    input  logic RST,
    input  logic en,
    input  logic match,
    input  logic clr,
    output logic done
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] cnt;

    assign done = (cnt == CW'(CYCLES));

    // Count consecutive matching cycles, restart on mismatch
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (!match)
                cnt <= '0;
            else if (!done)
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with debounce and strobes.
// KEYPAD_CLEAR_EN: '*' pulses clear_input and drops operator.
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_DIV        = 16,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       RST,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] keypad_input,
    output logic       read_input,
    output op_t        operator_input,
    output logic       equal_input,
    output logic       clear_input
);

    localparam int DW = $clog2(SCAN_DIV);

    logic [3:0]    row_s1;
    logic [3:0]    row_s2;
    scan_state_t   state;
    logic [1:0]    col;
    logic [DW-1:0] div;
    logic [3:0]    pat;
    logic [1:0]    row_idx;
    key_code_t     key;
    logic          any_low;
    logic          dwell_end;
    logic          db_en;
    logic          db_match;
    logic          db_clr;
    logic          db_done;
    logic          emit_go;

    assign col_out   = ~(4'b0001 << col);
    assign key       = key_decode(row_idx, col);
    assign any_low   = (row_s2 != 4'hF);
    assign dwell_end = (div == DW'(SCAN_DIV - 1));
    assign db_en     = (state == ST_DEBOUNCE) ||
                       (state == ST_RELEASE);
    assign db_match  = (state == ST_DEBOUNCE) ?
                       (row_s2 == pat) : !any_low;
    assign db_clr    = (state == ST_SCAN) ||
                       (state == ST_EMIT) || db_done;
    assign emit_go   = (state == ST_DEBOUNCE) && db_done;

    // Two-flop row synchronizer
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
        end else begin
            row_s1 <= row_in;
            row_s2 <= row_s1;
        end
    end

    keypad_debounce #(
        .CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
        .clk  (clk),
        .RST  (RST),
        .en   (db_en),
        .match(db_match),
        .clr  (db_clr),
        .done (db_done)
    );

    // Scan / debounce / emit / release sequencing
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state   <= ST_SCAN;
            col     <= 2'd0;
            div     <= '0;
            pat     <= 4'hF;
            row_idx <= 2'd0;
        end else begin
            unique case (state)
                ST_SCAN: begin
                    if (dwell_end) begin
                        div <= '0;
                        if (any_low) begin
                            pat     <= row_s2;
                            row_idx <= low_row(row_s2);
                            state   <= ST_DEBOUNCE;
                        end else begin
                            col <= col + 2'd1;
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (db_done)
                        state <= ST_EMIT;
                    else if (!db_match)
                        state <= ST_SCAN;
                end
                ST_EMIT: begin
                    state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (db_done) begin
                        state <= ST_SCAN;
                        col   <= 2'd0;
                        div   <= '0;
                    end
                end
            endcase
        end
    end

    // Load outputs on the edge into EMIT so strobes show there
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            keypad_input   <= 4'd0;
            read_input     <= 1'b0;
            operator_input <= OP_NONE;
            equal_input    <= 1'b0;
        end else begin
            read_input  <= 1'b0;
            equal_input <= 1'b0;
            if (emit_go) begin
                case (key)
                    K0, K1, K2, K3, K4,
                    K5, K6, K7, K8, K9: begin
                        keypad_input <= 4'(key);
                        read_input   <= 1'b1;
                    end
                    K_ADD: operator_input <= OP_ADD;
                    K_SUB: operator_input <= OP_SUB;
                    K_MUL: operator_input <= OP_MUL;
                    K_EQ:  equal_input    <= 1'b1;
`ifdef KEYPAD_CLEAR_EN
                    K_STAR: operator_input <= OP_NONE;
`endif
                    default: ;
                endcase
            end
        end
    end

`ifdef KEYPAD_CLEAR_EN
    logic clear_q;

    // Clear strobe for '*'
    always_ff @(posedge clk or posedge RST) begin
        if (RST)
            clear_q <= 1'b0;
        else
            clear_q <= emit_go && (key == K_STAR);
    end

    assign clear_input = clear_q;
`else
    assign clear_input = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: matrix model, event queue,
// per-cycle compare against expected key events.
module tb_keypad_scanner;

    localparam int SD  = 4;
    localparam int DC  = 8;
    localparam int LAT = 4 * SD + 2 + DC + 1;

    localparam int EV_READ = 0;
    localparam int EV_OP   = 1;
    localparam int EV_EQ   = 2;
    localparam int EV_CLR  = 3;

    typedef struct {
        int kind;
        int val;
        int deadline;
    } ev_t;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  keypad_input;
    logic        read_input;
    logic [2:0]  operator_input;
    logic        equal_input;
    logic        clear_input;

    logic [15:0] keys = '0;
    logic [2:0]  exp_op = 3'b000;
    ev_t         q[$];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    keypad_scanner #(
        .SCAN_DIV(SD),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk           (clk),
        .RST           (RST),
        .row_in        (row_in),
        .col_out       (col_out),
        .keypad_input  (keypad_input),
        .read_input    (read_input),
        .operator_input(operator_input),
        .equal_input   (equal_input),
        .clear_input   (clear_input)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive matrix: a pressed key shorts its row to its column
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_out[c])
                    row_in[r] = 1'b0;
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    task automatic consume(int kind, int val);
        ev_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: kind %0d val %0d cycle %0d",
                     kind, val, cyc);
        end else begin
            e = q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_val", val, e.val);
            chk("latency_ok", int'(cyc <= e.deadline), 1);
            if (e.kind == EV_OP)
                exp_op = e.val[2:0];
            else if (e.kind == EV_CLR)
                exp_op = 3'b000;
        end
    endtask

    // Per-cycle compare against the event model
    always @(negedge clk) begin
        if (RST) begin
            exp_op = 3'b000;
            chk("rst_col", int'(col_out), 14);
            chk("rst_kp", int'(keypad_input), 0);
            chk("rst_op", int'(operator_input), 0);
            chk("rst_strb", int'({read_input, equal_input,
                                  clear_input}), 0);
        end else begin
            chk("col_onehot", $countones(~col_out), 1);
            chk("strb_excl",
                int'($countones({read_input, equal_input,
                                 clear_input}) <= 1), 1);
            if (read_input)
                consume(EV_READ, int'(keypad_input));
            if (equal_input)
                consume(EV_EQ, 0);
            if (clear_input)
                consume(EV_CLR, 0);
            else if (operator_input != exp_op)
                consume(EV_OP, int'(operator_input));
            chk("op_hold", int'(operator_input), int'(exp_op));
            if (q.size() > 0 && cyc > q[0].deadline) begin
                checks++;
                errors++;
                $display("FAIL timeout: kind %0d val %0d cycle %0d",
                         q[0].kind, q[0].val, cyc);
                void'(q.pop_front());
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(int kind, int val);
        ev_t e;
        e.kind = kind;
        e.val = val;
        e.deadline = cyc + LAT;
        q.push_back(e);
    endtask

    task automatic drain(string name);
        chk(name, q.size(), 0);
        q.delete();
    endtask

    task automatic tap(int idx, int hold);
        keys[idx] = 1'b1;
        step(hold);
        keys[idx] = 1'b0;
        step(30);
    endtask

    initial begin
        step(3);
        chk("rst_col_lit", int'(col_out), 4'b1110);
        chk("rst_read_lit", int'(read_input), 0);

        // '7' held from reset
        keys[8] = 1'b1;
        RST = 1'b0;
        expect_ev(EV_READ, 7);
        step(60);
        chk("kp_7_lit", int'(keypad_input), 7);
        keys[8] = 1'b0;
        step(30);
        drain("drain_7");

        // 'B' then 'D'
        expect_ev(EV_OP, 3'b010);
        tap(7, 40);
        chk("op_sub_lit", int'(operator_input), 3'b010);
        expect_ev(EV_EQ, 0);
        tap(15, 40);
        chk("op_after_eq", int'(operator_input), 3'b010);
        drain("drain_bd");

        // Bouncing '5'
        repeat (5) begin
            keys[5] = 1'b1;
            step(3);
            keys[5] = 1'b0;
            step(1);
        end
        expect_ev(EV_READ, 5);
        tap(5, 50);
        chk("kp_5_lit", int'(keypad_input), 5);
        drain("drain_5");

        // '1' and '4' together, release '1' first
        keys[0] = 1'b1;
        keys[4] = 1'b1;
        expect_ev(EV_READ, 1);
        step(50);
        chk("kp_1_lit", int'(keypad_input), 1);
        keys[0] = 1'b0;
        step(40);
        keys[4] = 1'b0;
        step(30);
        drain("drain_14");

        // 'C' then '*'
        expect_ev(EV_OP, 3'b100);
        tap(11, 40);
        chk("op_mul_lit", int'(operator_input), 3'b100);
`ifdef KEYPAD_CLEAR_EN
        expect_ev(EV_CLR, 0);
        tap(12, 40);
        chk("op_clr_lit", int'(operator_input), 3'b000);
`else
        tap(12, 40);
        chk("op_keep_lit", int'(operator_input), 3'b100);
`endif
        drain("drain_cs");

        // Reset in the middle of debouncing '9'
        RST = 1'b1;
        step(2);
        keys[10] = 1'b1;
        step(1);
        RST = 1'b0;
        step(15);
        RST = 1'b1;
        #1;
        chk("midrst_col", int'(col_out), 4'b1110);
        chk("midrst_kp", int'(keypad_input), 0);
        chk("midrst_op", int'(operator_input), 0);
        chk("midrst_read", int'(read_input), 0);
        step(3);
        keys[10] = 1'b0;
        step(2);
        RST = 1'b0;
        step(40);
        drain("drain_9");

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
